// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - control bit map, opcodes, states and control-word decode for ctrl_sequencer
package ctrl_pkg;

    localparam int CTRL_BITS = 16;

    localparam int C_LOAD_A   = 0;
    localparam int C_LOAD_B   = 1;
    localparam int C_LOAD_O   = 2;
    localparam int C_SEL_B    = 3;
    localparam int C_SH_LOAD  = 4;
    localparam int C_SH_LEFT  = 5;
    localparam int C_SH_RIGHT = 6;
    localparam int C_SEL_SH   = 7;
    localparam int C_ALU_ADD  = 8;
    localparam int C_ALU_SUB  = 9;
    localparam int C_ALU_AND  = 10;
    localparam int C_ALU_OR   = 11;
    localparam int C_ACC_LOAD = 13;
    localparam int C_ACC_CLR  = 14;
    localparam int C_DONE     = 15;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_ACC_A,
        S_OP_B,
        S_SH_LOAD,
        S_SH_OP,
        S_ACC_SH,
        S_CNT_INIT,
        S_ITER,
        S_STORE,
        S_DONE
    } state_t;

    // Control word presented to the datapath for the whole cycle spent in a state.
    function automatic logic [CTRL_BITS-1:0] ctrl_word(input state_t state, input logic [2:0] op);
        logic [CTRL_BITS-1:0] w;
        w = '0;
        case (state)
            S_LOAD: begin
                w[C_LOAD_A] = 1'b1;
                w[C_LOAD_B] = 1'b1;
            end
            S_CLEAR: w[C_ACC_CLR] = 1'b1;
            S_ACC_A: begin
                w[C_ALU_ADD]  = 1'b1;
                w[C_ACC_LOAD] = 1'b1;
            end
            S_OP_B: begin
                w[C_SEL_B]    = 1'b1;
                w[C_ACC_LOAD] = 1'b1;
                case (op)
                    OP_SUB:  w[C_ALU_SUB] = 1'b1;
                    OP_AND:  w[C_ALU_AND] = 1'b1;
                    OP_OR:   w[C_ALU_OR]  = 1'b1;
                    default: w[C_ALU_ADD] = 1'b1;
                endcase
            end
            S_SH_LOAD: w[C_SH_LOAD] = 1'b1;
            S_SH_OP: begin
                if (op == OP_SHR) begin
                    w[C_SH_RIGHT] = 1'b1;
                end else begin
                    w[C_SH_LEFT] = 1'b1;
                end
            end
            S_ACC_SH: begin
                w[C_ALU_ADD]  = 1'b1;
                w[C_SEL_SH]   = 1'b1;
                w[C_ACC_LOAD] = 1'b1;
            end
            S_ITER: begin
                w[C_ALU_ADD]  = 1'b1;
                w[C_ACC_LOAD] = 1'b1;
            end
            S_STORE: w[C_LOAD_O] = 1'b1;
            S_DONE:  w[C_DONE]   = 1'b1;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - opcode-driven micro-sequencer producing the datapath control word
module ctrl_sequencer #(
    parameter int CTRL_WIDTH = 16,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [2:0]            i_opcode,
    input  logic [DATA_WIDTH-1:0] i_reg_b,
    input  logic                  i_flag,
    output logic [CTRL_WIDTH-1:0] o_control,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_carry
);
    import ctrl_pkg::*;

    state_t                r_state;
    state_t                w_next_state;
    logic [2:0]            r_opcode;
    logic [2:0]            w_next_op;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] r_count;
    logic [CTRL_WIDTH-1:0] r_control;
    logic [CTRL_WIDTH-1:0] w_control;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_carry;

    always_comb begin
        w_next_state = r_state;
        w_next_op    = r_opcode;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_op    = i_opcode;
                    w_next_state = (i_opcode == OP_NOP) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: w_next_state = S_CLEAR;
            S_CLEAR: begin
                case (r_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: w_next_state = S_ACC_A;
                    OP_SHL, OP_SHR:                w_next_state = S_SH_LOAD;
                    OP_MUL:                        w_next_state = S_CNT_INIT;
                    default:                       w_next_state = S_STORE;
                endcase
            end
            S_ACC_A:    w_next_state = S_OP_B;
            S_OP_B:     w_next_state = S_STORE;
            S_SH_LOAD:  w_next_state = S_SH_OP;
            S_SH_OP:    w_next_state = S_ACC_SH;
            S_ACC_SH:   w_next_state = S_STORE;
            // Register B is already loaded here, so a zero count skips ITER entirely.
            S_CNT_INIT: w_next_state = (i_reg_b == '0) ? S_STORE : S_ITER;
            S_ITER:     w_next_state = (r_count <= DATA_WIDTH'(1)) ? S_STORE : S_ITER;
            S_STORE:    w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
        w_control = CTRL_WIDTH'(ctrl_word(w_next_state, w_next_op));
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_opcode  <= OP_NOP;
            r_count   <= '0;
            r_control <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_carry   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_opcode  <= w_next_op;
            r_control <= w_control;
            r_busy    <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
            r_done    <= (w_next_state == S_DONE);
            if (w_accept) begin
                r_carry <= 1'b0;
            end else if (r_state == S_ACC_SH && r_opcode == OP_SHR) begin
                r_carry <= i_flag;
            end
            if (r_state == S_CNT_INIT) begin
                r_count <= i_reg_b;
            end else if (r_state == S_ITER && r_count != '0) begin
                r_count <= r_count - DATA_WIDTH'(1);
            end
        end
    end

    assign o_control = r_control;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_carry   = r_carry;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Control unit that drives the 4-bit microcontroller datapath's 16-bit one-hot control word and consumes the datapath's shifter flag.
- Accepts an opcode via a start/busy/done handshake and steps the datapath through a fixed micro-sequence: load operands, clear the accumulator, compute, store to the output register.
- Multiply is implemented as repeated addition, driven by an internal down-counter.
- Sits beside the datapath in the top level: control out, flag and Reg_B back in.

Parameters:
- CTRL_WIDTH, 16: width of the control word (one-hot bit map in package).
- DATA_WIDTH, 4: operand width; sets the iteration counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  3  operation, captured on start accept.
- reg_b  in  DATA_WIDTH  datapath Register B value (multiply count).
- flag  in  1  datapath shifter flag.
- control  out  CTRL_WIDTH  registered control word to the datapath.
- busy  out  1  high from LOAD through STORE.
- done  out  1  one-cycle pulse in DONE.
- carry  out  1  bit shifted out by SHR; 0 for all other ops.

Behaviour:
- Reset (reset=0, async): state IDLE, control=0, busy=0, done=0, carry=0, count=0. Reset mid-operation aborts immediately; no STORE is issued.
- control, busy and done are registered and update on the same edge as state, so each is valid for the whole cycle of the current state.
- Control bit map:
  - 0 LOAD_A, 1 LOAD_B, 2 LOAD_O, 3 SEL_B (MUX1 picks B), 4 SH_LOAD, 5 SH_LEFT, 6 SH_RIGHT, 7 SEL_SH (MUX2 picks shifter).
  - 8 ALU_ADD, 9 ALU_SUB, 10 ALU_AND, 11 ALU_OR, 12 spare (0), 13 ACC_LOAD, 14 ACC_CLR, 15 DONE.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL A, 101 SHR A, 110 MUL A*B, 111 NOP.
- Start accept: IDLE and start=1 at an edge. On that edge, capture opcode and clear carry. start in any other state is ignored (no queuing).
- States and control words:
  - LOAD: LOAD_A|LOAD_B.
  - CLEAR: ACC_CLR.
  - ACC_A: ALU_ADD|ACC_LOAD (ACC=0+A).
  - OP_B: op-specific ALU bit|SEL_B|ACC_LOAD. AND/OR first load A into ACC via ACC_A, then apply the op.
  - SH_LOAD: SH_LOAD (shifter takes A).
  - SH_OP: SH_LEFT or SH_RIGHT.
  - ACC_SH: ALU_ADD|SEL_SH|ACC_LOAD. For SHR, carry<=flag on the exit edge of this state.
  - CNT_INIT: control=0; count<=reg_b.
  - ITER: ALU_ADD|ACC_LOAD; count<=count-1.
  - STORE: LOAD_O.
  - DONE: DONE bit set, done=1, busy=0; next state is IDLE.
- Sequences:
  - ADD/SUB/AND/OR: LOAD, CLEAR, ACC_A, OP_B, STORE, DONE. done is high 6 cycles after accept.
  - SHL/SHR: LOAD, CLEAR, SH_LOAD, SH_OP, ACC_SH, STORE, DONE. done at 7 cycles.
  - MUL: LOAD, CLEAR, CNT_INIT, then ITER while count!=0 (exit when count reaches 0), then STORE, DONE. done at 5+B cycles.
    - B=0: zero ITER cycles; the result stored is 0.
    - B=15: 15 ITER cycles; no counter wrap.
  - NOP: DONE next cycle. done at 1 cycle; Output_Reg is unchanged.
- Width/arithmetic: the sequencer does no data arithmetic. Result width and wrap (8-bit two's complement for SUB) belong to the datapath. count is DATA_WIDTH bits and never decrements below 0.
- start held high continuously: a new accept occurs on the first IDLE cycle after DONE, giving one IDLE gap between operations.

Decomposition:
- Shared package ctrl_pkg holds:
  - the control bit index constants and the state enum;
  - the opcode constants;
  - a function mapping state + opcode to the control word.
- No sub-module; a single FSM plus counter.

Test Plan:
- Reset: assert reset=0 mid-MUL (count=3) -> control=0, busy=0, done=0 immediately; state IDLE after release; Output_Reg is not rewritten.
- ADD with A=9, B=6 and the datapath attached -> control sequence 0x0003, 0x4000, 0x2100, 0x2108, 0x0004, 0x8000; done at cycle 6; Output_Reg=15.
- SUB with A=2, B=5 -> Output_Reg=0xFD; done at cycle 6.
- SHR with A=5 -> Output_Reg=2, carry=1; done at cycle 7. SHL with A=9 -> Output_Reg=18, carry=0.
- MUL with A=7, B=15 -> exactly 15 ITER cycles; Output_Reg=105; done at cycle 20. MUL with B=0 -> zero ITER cycles; Output_Reg=0; done at cycle 5.
- Handshake: pulse start during busy -> ignored. start held high across two ADDs -> second accept is on the IDLE cycle after DONE. NOP -> done in 1 cycle with no LOAD_O.
